// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: PC width, jump select encodings,
// the sequencer state enum and the default reset PC.
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_J   = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN,
    ST_PEND
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the ID/hazard side (master) and the PC sequencer (slave):
// redirect sources and stall in, fetch address and status out.
interface pc_sequencer_if;
  import mips_pkg::*;

  logic            stall;
  logic            and_z_b;
  logic [PC_W-1:0] branch_adder;
  logic [1:0]      Jmp;
  logic [25:0]     jmp_addr;
  logic [PC_W-1:0] address_on_reg;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] pc2id;
  logic            flush_ifid;
  logic            redirect_pending;
  logic            align_err;

  modport master (
    output stall, and_z_b, branch_adder, Jmp, jmp_addr, address_on_reg,
    input  out_pc, pc2id, flush_ifid, redirect_pending, align_err
  );

  modport slave (
    input  stall, and_z_b, branch_adder, Jmp, jmp_addr, address_on_reg,
    output out_pc, pc2id, flush_ifid, redirect_pending, align_err
  );

endinterface

// File: rtl/pc_target_sel.sv
// Next-PC source selection: JR beats J beats taken branch beats PC+4.
// Redirect targets come out word-aligned, with the raw misalignment flagged.
module pc_target_sel
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] cur_pc,
  input  logic            and_z_b,
  input  logic [PC_W-1:0] branch_adder,
  input  logic [1:0]      jmp,
  input  logic [25:0]     jmp_addr,
  input  logic [PC_W-1:0] address_on_reg,
  output logic [PC_W-1:0] target,
  output logic            redirect,
  output logic            misaligned
);

  logic [PC_W-1:0] raw_target;

  // Reserved select 2'b11 falls through to the branch/sequential path
  always_comb begin
    raw_target = cur_pc + 32'd4;
    redirect   = 1'b0;
    case (jmp)
      JMP_JR: begin
        raw_target = address_on_reg;
        redirect   = 1'b1;
      end
      JMP_J: begin
        raw_target = {cur_pc[31:28], jmp_addr, 2'b00};
        redirect   = 1'b1;
      end
      default: begin
        if (and_z_b) begin
          raw_target = branch_adder;
          redirect   = 1'b1;
        end
      end
    endcase
  end

  assign misaligned = redirect && (raw_target[1:0] != 2'b00);
  assign target     = redirect ? {raw_target[PC_W-1:2], 2'b00} : raw_target;

endmodule

// File: rtl/pc_sequencer.sv
// PC register with stall hold, stall-deferred redirects, IF/ID flush
// generation and a sticky misaligned-target flag.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            align_err_q, align_err_d;
  logic            flush;

  logic [PC_W-1:0] sel_target;
  logic            sel_redirect;
  logic            sel_misaligned;

  pc_target_sel u_target_sel (
    .cur_pc         (pc_q),
    .and_z_b        (bus.and_z_b),
    .branch_adder   (bus.branch_adder),
    .jmp            (bus.Jmp),
    .jmp_addr       (bus.jmp_addr),
    .address_on_reg (bus.address_on_reg),
    .target         (sel_target),
    .redirect       (sel_redirect),
    .misaligned     (sel_misaligned)
  );

  // In PEND the first latched target wins; new redirect inputs are ignored
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    align_err_d = align_err_q;
    flush       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (sel_redirect && sel_misaligned) begin
          align_err_d = 1'b1;
        end
        if (!bus.stall) begin
          pc_d  = sel_target;
          flush = sel_redirect;
        end else if (sel_redirect) begin
          pend_pc_d = sel_target;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!bus.stall) begin
          pc_d    = pend_pc_q;
          flush   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.out_pc           = pc_q;
  assign bus.pc2id            = rst ? '0 : pc_q + 32'd4;
  assign bus.flush_ifid       = flush;
  assign bus.redirect_pending = (state_q == ST_PEND);
  assign bus.align_err        = align_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] TB_RESET_PC = 32'h0040_0000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;
  bit   chk_en;

  // Behavioural model: architectural PC, deferred-redirect slot, sticky error
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_err;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(TB_RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_sel(input logic [31:0] pc, input logic z,
                                    input logic [31:0] ba, input logic [1:0] j,
                                    input logic [25:0] ja, input logic [31:0] ar,
                                    output logic [31:0] raw, output bit redir);
    redir = 1'b1;
    if (j == 2'b10)      raw = ar;
    else if (j == 2'b01) raw = {pc[31:28], ja, 2'b00};
    else if (z)          raw = ba;
    else begin
      raw   = pc + 32'd4;
      redir = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_mis++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    logic [31:0] raw;
    bit          redir;
    bit          exp_flush;
    logic [31:0] exp_pc2id;
    model_sel(m_pc, bus.and_z_b, bus.branch_adder, bus.Jmp, bus.jmp_addr,
              bus.address_on_reg, raw, redir);
    if (rst)         exp_flush = 1'b0;
    else if (m_pend) exp_flush = !bus.stall;
    else             exp_flush = !bus.stall && redir;
    exp_pc2id = rst ? 32'h0 : m_pc + 32'd4;
    checkOutput({tag, ".out_pc"},  bus.out_pc,           m_pc);
    checkOutput({tag, ".pc2id"},   bus.pc2id,            exp_pc2id);
    checkOutput({tag, ".flush"},   {31'b0, bus.flush_ifid},       {31'b0, exp_flush});
    checkOutput({tag, ".pending"}, {31'b0, bus.redirect_pending}, {31'b0, m_pend});
    checkOutput({tag, ".align"},   {31'b0, bus.align_err},        {31'b0, m_err});
  endtask

  task automatic modelClock();
    logic [31:0] raw;
    bit          redir;
    logic [31:0] tgt;
    if (rst) begin
      m_pc   = TB_RESET_PC;
      m_pend = 1'b0;
      m_err  = 1'b0;
    end else if (m_pend) begin
      if (!bus.stall) begin
        m_pc   = m_pend_pc;
        m_pend = 1'b0;
      end
    end else begin
      model_sel(m_pc, bus.and_z_b, bus.branch_adder, bus.Jmp, bus.jmp_addr,
                bus.address_on_reg, raw, redir);
      tgt = redir ? (raw & 32'hFFFF_FFFC) : raw;
      if (redir && (raw % 4 != 0)) m_err = 1'b1;
      if (!bus.stall) m_pc = tgt;
      else if (redir) begin
        m_pend    = 1'b1;
        m_pend_pc = tgt;
      end
    end
  endtask

  // One cycle: drive inputs, check mid-cycle, clock, step the model
  task automatic applyStimulus(input string tag, input logic r, input logic s,
                               input logic z, input logic [31:0] ba,
                               input logic [1:0] j, input logic [25:0] ja,
                               input logic [31:0] ar);
    rst                = r;
    bus.stall          = s;
    bus.and_z_b        = z;
    bus.branch_adder   = ba;
    bus.Jmp            = j;
    bus.jmp_addr       = ja;
    bus.address_on_reg = ar;
    @(negedge clk);
    if (chk_en) checkModel(tag);
    @(posedge clk);
    modelClock();
    #1;
  endtask

  initial begin
    logic [31:0] r_ar, r_ba;
    n_vec  = 0;
    n_mis  = 0;
    chk_en = 1'b0;
    m_pc   = TB_RESET_PC;
    m_pend = 1'b0;
    m_pend_pc = '0;
    m_err  = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("rst0", 1, 0, 0, 0, 2'b00, 0, 0);
    chk_en = 1'b1;
    applyStimulus("rst1", 1, 0, 1, 32'h100, 2'b10, 26'h40, 32'h2000);
    checkOutput("reset_pc", bus.out_pc, 32'h0040_0000);

    applyStimulus("seq0", 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("seq_pc1", bus.out_pc, 32'h0040_0004);
    applyStimulus("seq1", 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("seq_pc2", bus.out_pc, 32'h0040_0008);
    applyStimulus("seq2", 0, 0, 0, 0, 2'b00, 0, 0);

    applyStimulus("jr_to_10", 0, 0, 0, 0, 2'b10, 0, 32'h0000_0010);
    checkOutput("at_10", bus.out_pc, 32'h0000_0010);
    applyStimulus("jump_wins", 0, 0, 1, 32'h0000_0100, 2'b01, 26'h0000_040, 0);
    checkOutput("jump_wins_pc", bus.out_pc, 32'h0000_0100);

    applyStimulus("stall1", 0, 1, 0, 0, 2'b10, 0, 32'h0000_2000);
    applyStimulus("stall2", 0, 1, 1, 32'h0000_9000, 2'b10, 0, 32'h0000_5000);
    checkOutput("stall_hold", bus.out_pc, 32'h0000_0100);
    applyStimulus("stall3", 0, 1, 0, 0, 2'b00, 0, 0);
    applyStimulus("release", 0, 0, 0, 0, 2'b01, 26'h0000_777, 0);
    checkOutput("deferred_pc", bus.out_pc, 32'h0000_2000);
    applyStimulus("after_rel", 0, 0, 0, 0, 2'b00, 0, 0);

    applyStimulus("to_top", 0, 0, 0, 0, 2'b10, 0, 32'hFFFF_FFFC);
    applyStimulus("wrap", 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("wrap_pc", bus.out_pc, 32'h0000_0000);
    checkOutput("wrap_no_err", {31'b0, bus.align_err}, 32'h0);

    applyStimulus("misalign", 0, 0, 0, 0, 2'b10, 0, 32'h0000_3003);
    checkOutput("aligned_pc", bus.out_pc, 32'h0000_3000);
    checkOutput("err_set", {31'b0, bus.align_err}, 32'h1);
    applyStimulus("err_hold0", 0, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus("err_hold1", 0, 1, 0, 0, 2'b00, 0, 0);
    checkOutput("err_sticky", {31'b0, bus.align_err}, 32'h1);
    applyStimulus("err_clr", 1, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("err_cleared", {31'b0, bus.align_err}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r_ar = $urandom & 32'hFFFF_FFFC;
      r_ba = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) r_ar = r_ar | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) r_ba = r_ba | 32'($urandom_range(1, 3));
      applyStimulus("rand", ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                    r_ba, 2'($urandom_range(0, 7) < 5 ? 0 : $urandom_range(1, 3)),
                    26'($urandom), r_ar);
    end

    applyStimulus("pend_enter", 0, 1, 0, 0, 2'b10, 0, 32'h0000_7000);
    checkOutput("pend_flag", {31'b0, bus.redirect_pending}, 32'h1);
    applyStimulus("pend_rst", 1, 1, 0, 0, 2'b00, 0, 0);
    checkOutput("pend_rst_pc", bus.out_pc, TB_RESET_PC);
    checkOutput("pend_rst_flag", {31'b0, bus.redirect_pending}, 32'h0);
    applyStimulus("post_rst0", 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("no_stale_fetch", bus.out_pc, TB_RESET_PC + 32'd4);
    applyStimulus("post_rst1", 0, 0, 0, 0, 2'b00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
